kick_control: RTL and testbench
===============================

# kick_control

Upstream sequencer for the kick counter. It turns a raw active-low push-button into a single-cycle `go` pulse and a periodic `en` tick stream for the kick counter. It watches the counter's `count` to detect the end of a kick and then enforces a cooldown before it accepts another press. It sits between the board key inputs and the kick counter stage.

## Interface
- `DIV`, 16'd50000: clock cycles per `en` tick (≥2).
- `MAX_COUNT`, 16'd43840: terminal value of the downstream counter; must match the counter's own maximum.
- `COOLDOWN_TICKS`, 8'd25: ticks spent in COOLDOWN after a kick completes (≥1).
- `DEBOUNCE_CYCLES`, 20'd500000: cycles the synchronised key must stay stable before the change is accepted. Used only when `KICK_DEBOUNCE_EN` is defined.
- `clk`, input, 1: system clock, rising-edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `key_n`, input, 1: raw button, asynchronous, active-low (0 = pressed).
- `count`, input, 16: current value of the downstream kick counter.
- `go`, output, 1: one-cycle start pulse to the downstream counter.
- `en`, output, 1: one-cycle count-enable tick.
- `busy`, output, 1: high in KICK, ACTIVE and COOLDOWN.
- `cooling`, output, 1: high only in COOLDOWN.
- `kicks`, output, 8: number of accepted presses; saturates at 255.

## Operation
- Input path: `key_n` passes through a 2-flop synchroniser, giving `key_s`. A rising edge of pressed (`~key_s`) is a press event.
- State machine, 2-bit, reset to IDLE:
  - IDLE → KICK on a press event.
  - KICK (exactly 1 cycle, `go`=1) → ACTIVE.
  - ACTIVE → COOLDOWN when `count == MAX_COUNT`.
  - COOLDOWN → IDLE once `COOLDOWN_TICKS` ticks have elapsed.
- Press events are ignored outside IDLE. They are neither queued nor counted.
- `kicks` increments on IDLE→KICK. It holds at 8'hFF once reached.
- Tick divider, 16-bit `div`:
  - Cleared in IDLE and KICK, and on entry to COOLDOWN.
  - Otherwise counts 0..DIV-1 and wraps.
  - A tick occurs when `div == DIV-1`.
- `en` = tick AND state==ACTIVE AND `count != MAX_COUNT`.
- Cooldown counter, 8-bit:
  - Loaded with `COOLDOWN_TICKS` on entry to COOLDOWN.
  - Decrements on each tick.
  - The exit to IDLE happens in the cycle where the counter is 1 and a tick occurs.
- All outputs are registered or decoded from registered state only; there is no combinational path from `count` to `go`.
- Reset values: `go`=0, `en`=0, `busy`=0, `cooling`=0, `kicks`=0, state IDLE, `div`=0, synchroniser flops=1 (released).
- Reset asserted mid-kick returns the block to IDLE immediately (asynchronous). `kicks` is cleared. A key still held at release does not fire until it is released and pressed again, because the edge detector's history starts at "released".

## Timing
- Without debounce: `key_n` falling at edge N gives `go`=1 in cycle N+3. That is 2 synchroniser cycles plus the registered edge/state.
- `go` is high for exactly one cycle. `busy` rises together with `go`.
- First `en` occurs DIV cycles after `go` falls. Subsequent `en` pulses are spaced exactly DIV cycles apart.
- `count == MAX_COUNT` in ACTIVE:
  - `en` is suppressed that same cycle.
  - COOLDOWN is entered on the next edge.
- COOLDOWN lasts COOLDOWN_TICKS×DIV cycles. A press in the first IDLE cycle is accepted.
- A press event arriving in the same cycle COOLDOWN exits is ignored, because the state is not yet IDLE.

## Configuration
- `KICK_DEBOUNCE_EN` defined:
  - A 20-bit stability counter follows `key_s`. It resets on any change and updates the debounced level after `DEBOUNCE_CYCLES` consecutive identical samples.
  - Press events come from the debounced level.
  - Press-to-`go` latency becomes DEBOUNCE_CYCLES+3 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no `go`.
- `KICK_DEBOUNCE_EN` undefined: the stability counter is not built, and press events come directly from `key_s`.

## Test plan
Bench parameters: DIV=4, MAX_COUNT=5, COOLDOWN_TICKS=2, DEBOUNCE_CYCLES=3. A behavioural counter model drives `count`.
- Single press, `key_n` low for 10 cycles → `go` high for exactly 1 cycle, 3 cycles after the fall. Then 5 `en` pulses, 4 cycles apart. `count` holds at 5 with no 6th `en`. `cooling` is high for 8 cycles. `busy` then drops and `kicks`=1.
- Press during ACTIVE and during COOLDOWN → no extra `go`. `kicks` stays 1 and the `en` spacing is undisturbed.
- `reset` pulsed while ACTIVE with `count`=3 → all outputs 0 in the same cycle, state IDLE. With `key_n` held low through the release, no `go` occurs until the key is released and pressed again.
- 300 press/complete cycles → `kicks` saturates at 255 and does not wrap.
- `KICK_DEBOUNCE_EN` defined:
  - A 2-cycle low glitch on `key_n` gives no `go`.
  - A 6-cycle low press gives `go` 6 cycles after the fall (DEBOUNCE_CYCLES+3).
- Back-to-back press in the first IDLE cycle after COOLDOWN → accepted, and `go` asserts with the normal 3-cycle latency.

Source files
------------

// File: rtl/kick_control.sv
// kick_control: push-button sequencer for the kick counter.
// Turns an active-low key into a one-cycle go pulse, then paces the
// downstream counter with periodic en ticks. After the counter reaches its
// terminal value, the block holds off new presses for a cooldown period.
// Optional build macro: KICK_DEBOUNCE_EN adds a stability filter on the
// synchronised key.
module kick_control #(
  parameter logic [15:0] DIV             = 16'd50000,
  parameter logic [15:0] MAX_COUNT       = 16'd43840,
  parameter logic [7:0]  COOLDOWN_TICKS  = 8'd25,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic [15:0] count,
  output logic        go,
  output logic        en,
  output logic        busy,
  output logic        cooling,
  output logic [7:0]  kicks
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CD_W   = 8;
  localparam int unsigned KCK_W  = 8;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] S_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] S_KICK   = 2'd1;
  localparam logic [ST_W-1:0] S_ACTIVE = 2'd2;
  localparam logic [ST_W-1:0] S_COOL   = 2'd3;

  localparam logic [CNT_W-1:0] DIV_LAST = DIV - CNT_W'(1);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_next;
  logic             key_meta;
  logic             key_s;
  logic [1:0]       warm;
  logic             armed;
  logic             key_lvl;
  logic             lvl_q;
  logic             press_ev;
  logic [CNT_W-1:0] div;
  logic             tick;
  logic [CD_W-1:0]  cd;
  logic             at_max;
  logic             cool_entry;

  // Two-flop synchroniser; both flops come out of reset reading "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // Arm the edge detector only once the synchroniser holds a real sample of
  // a released key; a key held through reset must be let go before it fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      if (warm[1] && key_s) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef KICK_DEBOUNCE_EN
  logic [19:0] stab;
  logic        key_db;

  // Accept a new key level only after it has been stable for the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab   <= 20'd0;
      key_db <= 1'b1;
    end else if (key_s == key_db) begin
      stab <= 20'd0;
    end else if (stab == DEBOUNCE_CYCLES - 20'd1) begin
      stab   <= 20'd0;
      key_db <= key_s;
    end else begin
      stab <= stab + 20'd1;
    end
  end

  assign key_lvl = key_db;
`else
  logic unused_cfg;

  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign key_lvl    = key_s;
`endif

  // Edge-detector history of the (possibly debounced) key level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= 1'b1;
    end else begin
      lvl_q <= key_lvl;
    end
  end

  assign press_ev   = armed & lvl_q & ~key_lvl;
  assign tick       = (div == DIV_LAST);
  assign at_max     = (count == MAX_COUNT);
  assign cool_entry = (state == S_ACTIVE) && at_max;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; presses outside IDLE are dropped, not queued.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (press_ev) begin
          state_next = S_KICK;
        end
      end
      S_KICK: begin
        state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (at_max) begin
          state_next = S_COOL;
        end
      end
      S_COOL: begin
        if (tick && (cd == CD_W'(1))) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Tick divider: parked at zero while idle/kicking and restarted on cooldown entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if ((state == S_IDLE) || (state == S_KICK) || cool_entry) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + CNT_W'(1);
    end
  end

  // Cooldown tick counter; the exit fires on the tick seen while it reads 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd <= '0;
    end else if (cool_entry) begin
      cd <= COOLDOWN_TICKS;
    end else if ((state == S_COOL) && tick && (cd != '0)) begin
      cd <= cd - CD_W'(1);
    end
  end

  // Accepted-press counter, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kicks <= '0;
    end else if ((state == S_IDLE) && press_ev && (kicks != {KCK_W{1'b1}})) begin
      kicks <= kicks + KCK_W'(1);
    end
  end

  // Registered outputs; go/busy/cooling track the state being entered so they
  // line up with the state register, and en never fires on the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go      <= 1'b0;
      en      <= 1'b0;
      busy    <= 1'b0;
      cooling <= 1'b0;
    end else begin
      go      <= (state_next == S_KICK);
      en      <= tick && (state == S_ACTIVE) && !at_max;
      busy    <= (state_next != S_IDLE);
      cooling <= (state_next == S_COOL);
    end
  end

endmodule

// File: tb/tb_kick_control.sv
// Directed bench for kick_control with a behavioural downstream counter.
// Build with KICK_DEBOUNCE_EN defined to also cover the debounce filter.
module tb_kick_control;

  localparam logic [15:0] DIV  = 16'd4;
  localparam logic [15:0] MAXC = 16'd5;
  localparam logic [7:0]  CDT  = 8'd2;
  localparam logic [19:0] DEB  = 20'd3;
`ifdef KICK_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n;
  logic [15:0] count;
  logic        go;
  logic        en;
  logic        busy;
  logic        cooling;
  logic [7:0]  kicks;

  int n_chk = 0;
  int n_err = 0;

  int run_id  = 0;
  int seen_id = 0;
  int cyc, go_n, go_first, go_last, en_n, en_first, en_last, gap_bad, cool_n, busy_n;

  always #5 clk = ~clk;

  kick_control #(
    .DIV(DIV),
    .MAX_COUNT(MAXC),
    .COOLDOWN_TICKS(CDT),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .count(count),
    .go(go),
    .en(en),
    .busy(busy),
    .cooling(cooling),
    .kicks(kicks)
  );

  // Downstream kick counter: restarts on go, advances on en up to MAXC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'd0;
    end else if (go) begin
      count <= 16'd0;
    end else if (en && (count < MAXC)) begin
      count <= count + 16'd1;
    end
  end

  // Per-run event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id  = run_id;
      cyc      = 0;
      go_n     = 0;
      go_first = -1;
      go_last  = -1;
      en_n     = 0;
      en_first = -1;
      en_last  = -1;
      gap_bad  = 0;
      cool_n   = 0;
      busy_n   = 0;
    end
    cyc = cyc + 1;
    if (go) begin
      go_n = go_n + 1;
      if (go_n == 1) go_first = cyc;
      go_last = cyc;
    end
    if (en) begin
      if ((en_n > 0) && ((cyc - en_last) != int'(DIV))) gap_bad = gap_bad + 1;
      en_n = en_n + 1;
      if (en_n == 1) en_first = cyc;
      en_last = cyc;
    end
    if (cooling) cool_n = cool_n + 1;
    if (busy) busy_n = busy_n + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    repeat (3) step();
    check("rst_go", int'(go), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cooling", int'(cooling), 0);
    check("rst_kicks", int'(kicks), 0);
    reset = 1'b0;
    repeat (5) step();

    // Single press with extra presses during ACTIVE and COOLDOWN.
    run_id = run_id + 1;
    key_n = 1'b0;
    for (int i = 1; i <= 44; i++) begin
      step();
      if (i == 10) key_n = 1'b1;
      if (i == 14) key_n = 1'b0;
      if (i == 18) key_n = 1'b1;
      if (i == 28) key_n = 1'b0;
      if (i == 32) key_n = 1'b1;
    end
    check("a_go_count", go_n, 1);
    check("a_go_latency", go_first, 1 + LAT);
    check("a_en_count", en_n, 5);
    check("a_en_first", en_first, 1 + LAT + 5);
    check("a_en_gap", gap_bad, 0);
    check("a_count_hold", int'(count), 5);
    check("a_cool_len", cool_n, 8);
    check("a_busy_len", busy_n, 31);
    check("a_busy_end", int'(busy), 0);
    check("a_kicks", int'(kicks), 1);

    // Press landing in the last COOLDOWN cycle is dropped.
    run_id = run_id + 1;
    key_n = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 4) key_n = 1'b1;
      if (i == 31) key_n = 1'b0;
      if (i == 37) key_n = 1'b1;
    end
    check("b_go_count", go_n, 1);
    check("b_kicks", int'(kicks), 2);

    // Press landing in the first IDLE cycle is accepted.
    run_id = run_id + 1;
    key_n = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 4) key_n = 1'b1;
      if (i == 32) key_n = 1'b0;
      if (i == 38) key_n = 1'b1;
    end
    check("c_go_count", go_n, 2);
    check("c_go_second", go_last, 33 + LAT);
    check("c_kicks", int'(kicks), 4);
    repeat (45) step();

    // Reset mid-ACTIVE with the key held through release.
    run_id = run_id + 1;
    key_n = 1'b0;
    repeat (20) step();
    check("d_pre_count", int'(count), 3);
    check("d_pre_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("d_rst_go", int'(go), 0);
    check("d_rst_en", int'(en), 0);
    check("d_rst_busy", int'(busy), 0);
    check("d_rst_cooling", int'(cooling), 0);
    check("d_rst_kicks", int'(kicks), 0);
    step();
    step();
    reset = 1'b0;
    run_id = run_id + 1;
    repeat (20) step();
    check("d_held_no_go", go_n, 0);
    key_n = 1'b1;
    repeat (6) step();
    key_n = 1'b0;
    repeat (LAT - 1) step();
    check("d_repress_early", int'(go), 0);
    step();
    check("d_repress_go", int'(go), 1);
    key_n = 1'b1;
    repeat (40) step();
    check("d_kicks", int'(kicks), 1);

    // Saturation of the accepted-press counter.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    for (int k = 1; k <= 300; k++) begin
      key_n = 1'b0;
      repeat (4) step();
      key_n = 1'b1;
      repeat (40) step();
      if (k == 254) check("e_kicks_254", int'(kicks), 254);
      if (k == 255) check("e_kicks_255", int'(kicks), 255);
    end
    check("e_kicks_sat", int'(kicks), 255);

`ifdef KICK_DEBOUNCE_EN
    // Short glitch is filtered; a long press goes through after the window.
    run_id = run_id + 1;
    key_n = 1'b0;
    step();
    step();
    key_n = 1'b1;
    repeat (20) step();
    check("f_glitch_no_go", go_n, 0);
    run_id = run_id + 1;
    key_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 6) key_n = 1'b1;
    end
    check("f_deb_go_count", go_n, 1);
    check("f_deb_latency", go_first, 7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
